// File: rtl/rgb_screen_mux.sv
// rgb_screen_mux: picks one of N_SRC screen sources and fades it out and back in on a source change.
// Latency: rgb_out is registered, one cycle after rgb_in/valid_in/level/cur_sel.
// Flow: no backpressure. Fade state advances only on frame_start pulses; rst overrides everything.
module rgb_screen_mux #(
   parameter int                   N_SRC      = 3,
   parameter int                   COLOR_W    = 4,
   parameter int                   FADE_STEPS = 8,
   parameter logic [3*COLOR_W-1:0] BG_RGB     = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         frame_start,
   input  logic [$clog2(N_SRC)-1:0]     sel_req,
   input  logic [N_SRC*3*COLOR_W-1:0]   rgb_in,
   input  logic [N_SRC-1:0]             valid_in,
   output logic [3*COLOR_W-1:0]         rgb_out,
   output logic [$clog2(N_SRC)-1:0]     cur_sel,
   output logic                         busy
);

   localparam int SW    = $clog2(N_SRC);
   localparam int PIX_W = 3 * COLOR_W;
   localparam int LS    = $clog2(FADE_STEPS);
   localparam int LW    = LS + 1;
   localparam int PW    = COLOR_W + LS + 1;

   // Widened source count so an out-of-range request can be detected
   // even when N_SRC is a power of two.
   localparam logic [SW:0]   N_SRC_V  = (SW+1)'(N_SRC);
   localparam logic [LW-1:0] LVL_FULL = LW'(FADE_STEPS);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);

   typedef enum logic [1:0] {
      STEADY   = 2'd0,
      FADE_OUT = 2'd1,
      FADE_IN  = 2'd2
   } state_t;

   state_t            state_q;
   logic [LW-1:0]     level_q;
   logic [SW-1:0]     target_q;
   logic [SW-1:0]     cur_sel_q;
   logic [PIX_W-1:0]  rgb_q;

   logic              sel_ok;
   logic [SW-1:0]     target_d;
   logic [PIX_W-1:0]  pix_sel;
   logic [PIX_W-1:0]  rgb_d;
   logic [PW-1:0]     prod;

   // Request legality and the target that a FADE_OUT pulse would commit to.
   always_comb begin
      sel_ok   = ({1'b0, sel_req} < N_SRC_V);
      target_d = sel_ok ? sel_req : target_q;
   end

   // Fade sequencer: dim the old source to zero, swap, brighten the new one.
   // A late request during FADE_OUT retargets the swap; FADE_IN ignores requests.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= STEADY;
         level_q   <= LVL_FULL;
         cur_sel_q <= '0;
         target_q  <= '0;
      end else if (frame_start) begin
         case (state_q)
            STEADY: begin
               if (sel_ok && (sel_req != cur_sel_q)) begin
                  target_q <= sel_req;
                  level_q  <= level_q - LVL_ONE;
                  state_q  <= FADE_OUT;
               end
            end
            FADE_OUT: begin
               target_q <= target_d;
               if (level_q != '0) begin
                  level_q <= level_q - LVL_ONE;
               end else begin
                  cur_sel_q <= target_d;
                  state_q   <= FADE_IN;
               end
            end
            FADE_IN: begin
               level_q <= level_q + LVL_ONE;
               if ((level_q + LVL_ONE) == LVL_FULL) begin
                  state_q <= STEADY;
               end
            end
            default: begin
               state_q <= STEADY;
            end
         endcase
      end
   end

   // Source pick with background fallback, then per-component brightness scaling.
   always_comb begin
      pix_sel = BG_RGB;
      for (int k = 0; k < N_SRC; k++) begin
         if ((cur_sel_q == SW'(k)) && valid_in[k]) begin
            pix_sel = rgb_in[k*PIX_W +: PIX_W];
         end
      end
      rgb_d = '0;
      prod  = '0;
      for (int c = 0; c < 3; c++) begin
         // Product width holds c*FADE_STEPS exactly, so full level passes c unchanged.
         prod = PW'(pix_sel[c*COLOR_W +: COLOR_W]) * PW'(level_q);
         rgb_d[c*COLOR_W +: COLOR_W] = COLOR_W'(prod >> LS);
      end
   end

   // Output pixel register.
   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_q <= '0;
      end else begin
         rgb_q <= rgb_d;
      end
   end

   assign rgb_out = rgb_q;
   assign cur_sel = cur_sel_q;
   assign busy    = (state_q == FADE_OUT) || (state_q == FADE_IN);

endmodule

// File: tb/tb_rgb_screen_mux.sv
// Bench for rgb_screen_mux with N_SRC=3, COLOR_W=4, FADE_STEPS=4, BG_RGB=12'h00F.
// A behavioural model is compared every cycle; directed steps check hand-computed values.
module tb_rgb_screen_mux;

   localparam int NS = 3;
   localparam int CW = 4;
   localparam int FS = 4;
   localparam logic [11:0] BG = 12'h00F;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_start = 1'b0;
   logic [1:0]  sel_req = 2'd0;
   logic [35:0] rgb_in = {12'h0F0, 12'hABC, 12'hFFF};
   logic [2:0]  valid_in = 3'b111;
   logic [11:0] rgb_out;
   logic [1:0]  cur_sel;
   logic        busy;

   int n_total = 0;
   int n_pass  = 0;
   bit chk_en  = 1'b0;

   rgb_screen_mux #(
      .N_SRC(NS), .COLOR_W(CW), .FADE_STEPS(FS), .BG_RGB(BG)
   ) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .sel_req(sel_req),
      .rgb_in(rgb_in), .valid_in(valid_in), .rgb_out(rgb_out),
      .cur_sel(cur_sel), .busy(busy)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // phase: 0 steady, 1 dimming, 2 brightening
   int          m_phase = 0;
   int          m_lvl   = FS;
   int          m_cur   = 0;
   int          m_tgt   = 0;
   logic [11:0] m_rgb   = 12'h000;

   function automatic logic [11:0] fade(input logic [11:0] p, input int lvl);
      logic [11:0] r;
      int c;
      r = 12'h000;
      for (int i = 0; i < 3; i++) begin
         c = int'((p >> (4*i)) & 12'h00F);
         r = r | (12'((c * lvl) / FS) << (4*i));
      end
      return r;
   endfunction

   function automatic logic [11:0] source_pixel(input int src);
      logic [35:0] all;
      all = rgb_in;
      if (valid_in[src]) return all[src*12 +: 12];
      return BG;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_lvl = FS; m_cur = 0; m_tgt = 0; m_rgb = 12'h000;
      end else begin
         m_rgb = fade(source_pixel(m_cur), m_lvl);
         if (frame_start) begin
            if (m_phase == 0) begin
               if (int'(sel_req) < NS && int'(sel_req) != m_cur) begin
                  m_tgt = int'(sel_req); m_lvl = m_lvl - 1; m_phase = 1;
               end
            end else if (m_phase == 1) begin
               if (int'(sel_req) < NS) m_tgt = int'(sel_req);
               if (m_lvl > 0) m_lvl = m_lvl - 1;
               else begin m_cur = m_tgt; m_phase = 2; end
            end else begin
               m_lvl = m_lvl + 1;
               if (m_lvl == FS) m_phase = 0;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         n_total++;
         if (rgb_out === m_rgb && int'(cur_sel) == m_cur && cur_sel !== 2'bxx
             && busy === (m_phase != 0)) begin
            n_pass++;
         end else begin
            $display("FAIL model t=%0t rgb_out=%h cur_sel=%0d busy=%b required rgb_out=%h cur_sel=%0d busy=%0d",
                     $time, rgb_out, cur_sel, busy, m_rgb, m_cur, (m_phase != 0));
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One-cycle frame_start, then one more cycle so rgb_out shows the new level.
   task automatic pulse(input logic [1:0] sel);
      sel_req = sel;
      frame_start = 1'b1;
      step(1);
      frame_start = 1'b0;
      step(1);
   endtask

   // ---------------- stimulus ----------------
   logic [11:0] exp_sw [9] = '{12'hBBB, 12'h777, 12'h333, 12'h000, 12'h000,
                               12'h030, 12'h070, 12'h0B0, 12'h0F0};

   initial begin
      // Reset with source 0 = FFF, all valid.
      step(1);
      chk_en = 1'b1;
      step(1);
      check("reset_rgb", int'(rgb_out), 'h000);
      check("reset_sel", int'(cur_sel), 0);
      check("reset_busy", int'(busy), 0);
      rst = 1'b0;
      step(1);
      check("release_rgb", int'(rgb_out), 'hFFF);

      // Invalid active source shows the background colour, then recovers.
      valid_in = 3'b110;
      step(1);
      check("bg_rgb", int'(rgb_out), 'h00F);
      valid_in = 3'b111;
      step(1);
      check("bg_recover", int'(rgb_out), 'hFFF);

      // Requesting the already displayed source changes nothing.
      pulse(2'd0);
      check("same_sel_busy", int'(busy), 0);

      // Full switch 0 -> 2.
      for (int i = 0; i < 9; i++) begin
         pulse(2'd2);
         check($sformatf("switch_rgb_%0d", i+1), int'(rgb_out), int'(exp_sw[i]));
         check($sformatf("switch_sel_%0d", i+1), int'(cur_sel), (i < 4) ? 0 : 2);
         check($sformatf("switch_busy_%0d", i+1), int'(busy), (i < 8) ? 1 : 0);
      end

      // Out-of-range request in STEADY is ignored.
      pulse(2'd3);
      check("oor_sel", int'(cur_sel), 2);
      check("oor_busy", int'(busy), 0);
      check("oor_rgb", int'(rgb_out), 'h0F0);

      // Back to source 0 via reset, then retarget 1 -> 2 mid fade-out.
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      rgb_in = {12'h0F0, 12'hABC, 12'h8C4};
      step(1);
      check("src0_new_rgb", int'(rgb_out), 'h8C4);
      pulse(2'd1);
      check("retarget_lvl3", int'(rgb_out), 'h693);
      pulse(2'd1);
      for (int i = 0; i < 3; i++) begin
         pulse(2'd2);
         check($sformatf("retarget_sel_%0d", i), int'(cur_sel), (i < 2) ? 0 : 2);
      end
      // FADE_IN ignores requests, including one for a different source.
      for (int i = 0; i < 4; i++) pulse(2'd1);
      check("retarget_final_sel", int'(cur_sel), 2);
      check("retarget_final_busy", int'(busy), 0);

      // Reset wins over frame_start mid fade-out at level 2 (fading 2 -> 1).
      pulse(2'd1);
      pulse(2'd1);
      check("pre_abort_rgb", int'(rgb_out), 'h070);
      check("pre_abort_busy", int'(busy), 1);
      rst = 1'b1;
      frame_start = 1'b1;
      sel_req = 2'd1;
      step(1);
      frame_start = 1'b0;
      check("abort_rgb", int'(rgb_out), 'h000);
      check("abort_sel", int'(cur_sel), 0);
      check("abort_busy", int'(busy), 0);
      rst = 1'b0;
      step(1);
      check("abort_full_lvl", int'(rgb_out), 'h8C4);
      step(2);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
